// File: rtl/dmem_pkg.sv
// Shared types for the data-memory responder: FSM states, access size codes
// and the width of the SRAM latency counter.
package dmem_pkg;

    localparam int LAT_CNT_W = 3;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        WAIT  = 2'd1,
        MERGE = 2'd2,
        DONE  = 2'd3
    } state_e;

    typedef enum logic [1:0] {
        SZ_B = 2'd0,
        SZ_H = 2'd1,
        SZ_W = 2'd2
    } size_e;

endpackage

// File: rtl/dmem_lane_align.sv
// Lane alignment for a word-wide SRAM without byte enables: extracts and
// extends sub-word loads, and merges sub-word store data into a read word.
import dmem_pkg::*;

module dmem_lane_align (
    input  size_e       size,
    input  logic [1:0]  offset,
    input  logic        ld_unsigned,
    input  logic [31:0] rd_word,
    input  logic [31:0] merge_word,
    input  logic [31:0] wdata,
    output logic [31:0] load_data,
    output logic [31:0] store_word
);

    // Pick the addressed lane and sign- or zero-extend it to 32 bits.
    function automatic logic [31:0] load_extend(input logic [31:0] word, input size_e sz,
                                                 input logic [1:0] off, input logic uns);
        logic signed [7:0]  b;
        logic signed [15:0] h;
        logic [31:0]        r;
        b = word[{off, 3'b000} +: 8];
        h = off[1] ? word[31:16] : word[15:0];
        case (sz)
            SZ_B:    r = uns ? {24'h0, b} : 32'(b);
            SZ_H:    r = uns ? {16'h0, h} : 32'(h);
            default: r = word;
        endcase
        return r;
    endfunction

    // Overwrite the addressed lane of the read word with the low bits of the store data.
    function automatic logic [31:0] store_merge(input logic [31:0] word, input logic [31:0] wd,
                                                input size_e sz, input logic [1:0] off);
        logic [31:0] r;
        r = word;
        case (sz)
            SZ_B:    r[{off, 3'b000} +: 8]        = wd[7:0];
            SZ_H:    r[{off[1], 4'b0000} +: 16]   = wd[15:0];
            default: r = wd;
        endcase
        return r;
    endfunction

    // Both lane paths are purely combinational.
    always_comb begin
        load_data  = load_extend(rd_word, size, offset, ld_unsigned);
        store_word = store_merge(merge_word, wdata, size, offset);
    end

endmodule

// File: rtl/dmem_responder.sv
// Data-memory responder: serves loads/stores from a fixed-latency word SRAM,
// doing sub-word stores as read-modify-write and stalling until done.
// Optional feature: define DMEM_MISALIGN_TRAP_EN to trap misaligned halves/words
// without touching the SRAM (otherwise low address bits are aligned down).
import dmem_pkg::*;

module dmem_responder #(
    parameter int ADDR_W   = 14,
    parameter int SRAM_LAT = 1
) (
    input  logic              CLK,
    input  logic              rst,
    input  logic              MEM_Rd_En,
    input  logic              MEM_Wr_En,
    input  logic              LB,
    input  logic              LH,
    input  logic              SB,
    input  logic              SH,
    input  logic              ld_unsigned,
    input  logic [31:0]       addr,
    input  logic [31:0]       wdata,
    output logic [31:0]       rdata,
    output logic              rd_valid,
    output logic              stall,
    output logic              misaligned,
    output logic              sram_en,
    output logic              sram_we,
    output logic [ADDR_W-1:0] sram_addr,
    output logic [31:0]       sram_wdata,
    input  logic [31:0]       sram_rdata
);

    localparam logic [LAT_CNT_W-1:0] LAT_INIT = LAT_CNT_W'(SRAM_LAT);

    state_e               state, state_nx;
    logic [LAT_CNT_W-1:0] lat_cnt;
    logic                 lat_last;

    logic                 req, req_store, mis_req;
    size_e                req_size;

    logic [ADDR_W+1:0]    addr_p0;
    logic [31:0]          wdata_p0;
    size_e                size_p0;
    logic                 uns_p0, store_p0, mis_p0;
    logic [31:0]          rword_p1;

    logic [31:0]          load_data, store_word;
    logic                 unused_addr_hi;

    assign unused_addr_hi = ^addr[31:ADDR_W+2];
    assign req            = MEM_Rd_En | MEM_Wr_En;
    assign req_store      = MEM_Wr_En;
    assign lat_last       = (lat_cnt == LAT_CNT_W'(1));

    // Decode the access size of the incoming request; a store wins when both enables are high.
    always_comb begin
        req_size = SZ_W;
        if (req_store) begin
            if (SB)      req_size = SZ_B;
            else if (SH) req_size = SZ_H;
        end else begin
            if (LB)      req_size = SZ_B;
            else if (LH) req_size = SZ_H;
        end
    end

`ifdef DMEM_MISALIGN_TRAP_EN
    // Flag halves on odd addresses and words off a word boundary.
    always_comb begin
        mis_req = ((req_size == SZ_H) && addr[0]) || ((req_size == SZ_W) && (addr[1:0] != 2'b00));
    end
`else
    assign mis_req = 1'b0;
`endif

    dmem_lane_align u_lane (
        .size        (size_p0),
        .offset      (addr_p0[1:0]),
        .ld_unsigned (uns_p0),
        .rd_word     (sram_rdata),
        .merge_word  (rword_p1),
        .wdata       (wdata_p0),
        .load_data   (load_data),
        .store_word  (store_word)
    );

    // FSM state register.
    always_ff @(posedge CLK or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_nx;
    end

    // Next-state logic: word stores and traps skip the read; sub-word stores merge after it.
    always_comb begin
        state_nx = state;
        case (state)
            IDLE: begin
                if (req) begin
                    if (mis_req || (req_store && (req_size == SZ_W))) state_nx = DONE;
                    else                                               state_nx = WAIT;
                end
            end
            WAIT:    if (lat_last) state_nx = store_p0 ? MERGE : DONE;
            MERGE:   state_nx = DONE;
            default: state_nx = IDLE;
        endcase
    end

    // Request latch, latency counter, held read word and the registered load result.
    always_ff @(posedge CLK or posedge rst) begin
        if (rst) begin
            addr_p0  <= '0;
            wdata_p0 <= '0;
            size_p0  <= SZ_W;
            uns_p0   <= 1'b0;
            store_p0 <= 1'b0;
            mis_p0   <= 1'b0;
            lat_cnt  <= '0;
            rword_p1 <= '0;
            rdata    <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (req) begin
                        addr_p0  <= addr[ADDR_W+1:0];
                        wdata_p0 <= wdata;
                        size_p0  <= req_size;
                        uns_p0   <= ld_unsigned;
                        store_p0 <= req_store;
                        mis_p0   <= mis_req;
                        lat_cnt  <= LAT_INIT;
                    end
                end
                WAIT: begin
                    lat_cnt <= lat_cnt - LAT_CNT_W'(1);
                    if (lat_last) begin
                        if (store_p0) rword_p1 <= sram_rdata;
                        else          rdata    <= load_data;
                    end
                end
                default: ;
            endcase
        end
    end

    // Outputs: IDLE drives the SRAM straight from the request, MERGE writes the merged word.
    always_comb begin
        stall      = 1'b0;
        sram_en    = 1'b0;
        sram_we    = 1'b0;
        sram_addr  = addr_p0[ADDR_W+1:2];
        sram_wdata = store_word;
        rd_valid   = 1'b0;
        misaligned = 1'b0;
        case (state)
            IDLE: begin
                sram_addr  = addr[ADDR_W+1:2];
                sram_wdata = wdata;
                if (req) begin
                    stall   = 1'b1;
                    sram_en = ~mis_req;
                    sram_we = ~mis_req & req_store & (req_size == SZ_W);
                end
            end
            WAIT:  stall = 1'b1;
            MERGE: begin
                stall   = 1'b1;
                sram_en = 1'b1;
                sram_we = 1'b1;
            end
            default: begin
                rd_valid   = ~store_p0 & ~mis_p0;
                misaligned = mis_p0;
            end
        endcase
    end

endmodule

// File: tb/tb_dmem_responder.sv
// Bench for dmem_responder: two instances (SRAM latency 1 and 3), each with
// its own behavioural SRAM, driven from a directed vector table plus hand
// sequences for reset-in-flight and misaligned access.
module tb_dmem_responder;

    localparam int OP_LW = 0, OP_LH = 1, OP_LB = 2, OP_SW = 3, OP_SH = 4, OP_SB = 5, OP_SBX = 6;

    typedef struct {
        bit          sel;
        int          op;
        bit          uns;
        logic [31:0] a;
        logic [31:0] wd;
        int          st;
        bit          rdv;
        logic [31:0] rdat;
        int          nrd;
        int          nwr;
        logic [13:0] wa;
        bit          gap;
    } vec_t;

    logic        CLK = 1'b0;
    logic        rst = 1'b1;
    logic        preload = 1'b1;
    bit          sel = 1'b0;
    logic        rd_en = 1'b0, wr_en = 1'b0, lb = 1'b0, lh = 1'b0, sb = 1'b0, sh = 1'b0, uns = 1'b0;
    logic [31:0] addr = '0, wdata = '0;

    logic [31:0] rdata1, rdata3, swd1, swd3, srd1, srd3;
    logic        rdv1, rdv3, stall1, stall3, mis1, mis3, en1, en3, we1, we3;
    logic [13:0] sa1, sa3;

    logic [31:0] mem1 [0:16383];
    logic [31:0] mem3 [0:16383];
    logic [31:0] pipe1;
    logic [31:0] pipe3 [0:2];
    int          rdn1, wrn1, rdn3, wrn3;
    logic [13:0] wa1, wa3;

    int total = 0;
    int bad   = 0;

    always #5 CLK = ~CLK;

    dmem_responder #(.ADDR_W(14), .SRAM_LAT(1)) dut1 (
        .CLK(CLK), .rst(rst), .MEM_Rd_En(rd_en & ~sel), .MEM_Wr_En(wr_en & ~sel),
        .LB(lb), .LH(lh), .SB(sb), .SH(sh), .ld_unsigned(uns), .addr(addr), .wdata(wdata),
        .rdata(rdata1), .rd_valid(rdv1), .stall(stall1), .misaligned(mis1),
        .sram_en(en1), .sram_we(we1), .sram_addr(sa1), .sram_wdata(swd1), .sram_rdata(srd1)
    );

    dmem_responder #(.ADDR_W(14), .SRAM_LAT(3)) dut3 (
        .CLK(CLK), .rst(rst), .MEM_Rd_En(rd_en & sel), .MEM_Wr_En(wr_en & sel),
        .LB(lb), .LH(lh), .SB(sb), .SH(sh), .ld_unsigned(uns), .addr(addr), .wdata(wdata),
        .rdata(rdata3), .rd_valid(rdv3), .stall(stall3), .misaligned(mis3),
        .sram_en(en3), .sram_we(we3), .sram_addr(sa3), .sram_wdata(swd3), .sram_rdata(srd3)
    );

    assign srd1 = pipe1;
    assign srd3 = pipe3[2];

    // Behavioural SRAMs: latency 1 and 3, poison value when no read was issued.
    always @(posedge CLK) begin
        if (preload) begin
            mem1[4]  <= 32'h8899AABB;
            mem1[8]  <= 32'h11223344;
            mem1[16] <= 32'h55667788;
            mem1[20] <= 32'hA5A5A5A5;
            mem3[32] <= 32'h01020304;
            mem3[33] <= 32'hF0E0D0C0;
            rdn1 <= 0; wrn1 <= 0; rdn3 <= 0; wrn3 <= 0;
            wa1  <= '0; wa3 <= '0;
        end else begin
            if (en1 && we1)  begin mem1[sa1] <= swd1; wrn1 <= wrn1 + 1; wa1 <= sa1; end
            if (en1 && !we1) rdn1 <= rdn1 + 1;
            if (en3 && we3)  begin mem3[sa3] <= swd3; wrn3 <= wrn3 + 1; wa3 <= sa3; end
            if (en3 && !we3) rdn3 <= rdn3 + 1;
        end
        pipe1    <= (en1 && !we1) ? mem1[sa1] : 32'hDEAD0001;
        pipe3[0] <= (en3 && !we3) ? mem3[sa3] : 32'hDEAD0003;
        pipe3[1] <= pipe3[0];
        pipe3[2] <= pipe3[1];
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h", nm, act, exp);
        end
    endtask

    function automatic vec_t mk(bit s, int op, bit u, logic [31:0] a, logic [31:0] wd, int st, bit rdv,
                                logic [31:0] rdat, int nrd, int nwr, logic [13:0] wa, bit gap);
        vec_t v;
        v.sel = s; v.op = op; v.uns = u; v.a = a; v.wd = wd; v.st = st; v.rdv = rdv;
        v.rdat = rdat; v.nrd = nrd; v.nwr = nwr; v.wa = wa; v.gap = gap;
        return v;
    endfunction

    // Apply one access, count stall cycles, sample DONE, then compare everything.
    task automatic apply(input vec_t v, input string nm, input bit exp_mis);
        int          stalls, r0, w0;
        bit          done;
        logic        got_rdv, got_mis;
        logic [31:0] got_rdata;
        sel   = v.sel;
        rd_en = (v.op <= OP_LB) || (v.op == OP_SBX);
        wr_en = (v.op >= OP_SW);
        lb    = (v.op == OP_LB);
        lh    = (v.op == OP_LH);
        sb    = (v.op == OP_SB) || (v.op == OP_SBX);
        sh    = (v.op == OP_SH);
        uns   = v.uns;
        addr  = v.a;
        wdata = v.wd;
        r0 = sel ? rdn3 : rdn1;
        w0 = sel ? wrn3 : wrn1;
        stalls = 0; done = 0; got_rdv = 0; got_mis = 0; got_rdata = '0;
        for (int c = 0; c < 20 && !done; c++) begin
            @(negedge CLK);
            if (sel ? stall3 : stall1) stalls++;
            else begin
                done      = 1;
                got_rdv   = sel ? rdv3 : rdv1;
                got_mis   = sel ? mis3 : mis1;
                got_rdata = sel ? rdata3 : rdata1;
            end
            @(posedge CLK);
            #1;
        end
        if (!done) begin
            total++; bad++;
            $display("FAIL %s timeout: got stall after 20 cycles want release", nm);
        end
        chk({nm, " stall"}, stalls, v.st);
        chk({nm, " rd_valid"}, {31'b0, got_rdv}, {31'b0, v.rdv});
        chk({nm, " misaligned"}, {31'b0, got_mis}, {31'b0, exp_mis});
        chk({nm, " rdata"}, got_rdata, v.rdat);
        chk({nm, " reads"}, (sel ? rdn3 : rdn1) - r0, v.nrd);
        chk({nm, " writes"}, (sel ? wrn3 : wrn1) - w0, v.nwr);
        if (v.nwr != 0) chk({nm, " waddr"}, {18'b0, sel ? wa3 : wa1}, {18'b0, v.wa});
        if (v.gap) begin
            rd_en = 0; wr_en = 0; lb = 0; lh = 0; sb = 0; sh = 0; uns = 0;
            @(posedge CLK);
            #1;
        end
    endtask

    vec_t vt [0:20];
    vec_t vm;

    initial begin
        int w0;
        vt[0]  = mk(0, OP_LB, 0, 32'h11, 32'h0,        2, 1, 32'hFFFFFFAA, 1, 0, 14'h0,  1);
        vt[1]  = mk(0, OP_LB, 1, 32'h11, 32'h0,        2, 1, 32'h000000AA, 1, 0, 14'h0,  1);
        vt[2]  = mk(0, OP_LH, 0, 32'h12, 32'h0,        2, 1, 32'hFFFF8899, 1, 0, 14'h0,  1);
        vt[3]  = mk(0, OP_LH, 1, 32'h10, 32'h0,        2, 1, 32'h0000AABB, 1, 0, 14'h0,  1);
        vt[4]  = mk(0, OP_LB, 0, 32'h13, 32'h0,        2, 1, 32'hFFFFFF88, 1, 0, 14'h0,  1);
        vt[5]  = mk(0, OP_LW, 0, 32'h10, 32'h0,        2, 1, 32'h8899AABB, 1, 0, 14'h0,  1);
        vt[6]  = mk(0, OP_SH, 0, 32'h22, 32'h0000BEEF, 3, 0, 32'h8899AABB, 1, 1, 14'h08, 1);
        vt[7]  = mk(0, OP_LW, 0, 32'h20, 32'h0,        2, 1, 32'hBEEF3344, 1, 0, 14'h0,  1);
        vt[8]  = mk(0, OP_SW, 0, 32'h30, 32'hCAFEF00D, 1, 0, 32'hBEEF3344, 0, 1, 14'h0C, 1);
        vt[9]  = mk(0, OP_LW, 0, 32'h30, 32'h0,        2, 1, 32'hCAFEF00D, 1, 0, 14'h0,  1);
        vt[10] = mk(0, OP_SB, 0, 32'h31, 32'h12345677, 3, 0, 32'hCAFEF00D, 1, 1, 14'h0C, 1);
        vt[11] = mk(0, OP_LB, 0, 32'h31, 32'h0,        2, 1, 32'h00000077, 1, 0, 14'h0,  1);
        vt[12] = mk(0, OP_LW, 0, 32'h30, 32'h0,        2, 1, 32'hCAFE770D, 1, 0, 14'h0,  1);
        vt[13] = mk(0, OP_SBX, 0, 32'h30, 32'hFFFFFFAB, 3, 0, 32'hCAFE770D, 1, 1, 14'h0C, 1);
        vt[14] = mk(0, OP_LW, 0, 32'h30, 32'h0,        2, 1, 32'hCAFE77AB, 1, 0, 14'h0,  1);
        vt[15] = mk(0, OP_LB, 1, 32'h12, 32'h0,        2, 1, 32'h00000099, 1, 0, 14'h0,  1);
        vt[16] = mk(0, OP_LH, 0, 32'h22, 32'h0,        2, 1, 32'hFFFFBEEF, 1, 0, 14'h0,  1);
        vt[17] = mk(1, OP_LW, 0, 32'h80, 32'h0,        4, 1, 32'h01020304, 1, 0, 14'h0,  0);
        vt[18] = mk(1, OP_LW, 0, 32'h84, 32'h0,        4, 1, 32'hF0E0D0C0, 1, 0, 14'h0,  0);
        vt[19] = mk(1, OP_SB, 0, 32'h86, 32'h0000005A, 5, 0, 32'hF0E0D0C0, 1, 1, 14'h21, 1);
        vt[20] = mk(1, OP_LW, 0, 32'h84, 32'h0,        4, 1, 32'hF05AD0C0, 1, 0, 14'h0,  1);

        // Reset state of both instances.
        repeat (3) @(posedge CLK);
        @(negedge CLK);
        chk("reset rdata1", rdata1, 32'h0);
        chk("reset ctl1", {26'b0, rdv1, stall1, mis1, en1, we1, 1'b0}, 32'h0);
        chk("reset rdata3", rdata3, 32'h0);
        chk("reset ctl3", {26'b0, rdv3, stall3, mis3, en3, we3, 1'b0}, 32'h0);
        @(posedge CLK);
        #1;
        rst = 0;
        preload = 0;
        @(posedge CLK);
        #1;

        for (int i = 0; i < 21; i++) apply(vt[i], $sformatf("v%0d", i), 1'b0);
        chk("mem SH merge", mem1[8], 32'hBEEF3344);
        chk("mem SB lat3", mem3[33], 32'hF05AD0C0);

        // Reset while an SB sits in WAIT: no write reaches the SRAM.
        sel = 0; rd_en = 0; wr_en = 1; sb = 1; addr = 32'h51; wdata = 32'h000000EE;
        w0 = wrn1;
        @(negedge CLK);
        chk("rmw idle stall", {31'b0, stall1}, 32'h1);
        @(posedge CLK);
        #1;
        chk("rmw in wait stall", {31'b0, stall1}, 32'h1);
        rst = 1; wr_en = 0; sb = 0;
        @(negedge CLK);
        chk("rst mid rdata", rdata1, 32'h0);
        chk("rst mid ctl", {26'b0, rdv1, stall1, mis1, en1, we1, 1'b0}, 32'h0);
        @(posedge CLK);
        #1;
        rst = 0;
        repeat (5) @(posedge CLK);
        #1;
        chk("rst mid mem", mem1[20], 32'hA5A5A5A5);
        chk("rst mid writes", wrn1 - w0, 0);

        // Word load at a non-word-aligned address.
`ifdef DMEM_MISALIGN_TRAP_EN
        vm = mk(0, OP_LW, 0, 32'h42, 32'h0, 1, 0, 32'h0, 0, 0, 14'h0, 1);
        apply(vm, "mis LW", 1'b1);
`else
        vm = mk(0, OP_LW, 0, 32'h42, 32'h0, 2, 1, 32'h55667788, 1, 0, 14'h0, 1);
        apply(vm, "mis LW", 1'b0);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
